// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Drives open-drain clock/data pads through output enables and reports ACK or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES     = 5000,
  parameter int START_SETUP_CYCLES = 1000,
  parameter int FIRST_EDGE_TIMEOUT = 750000,
  parameter int FRAME_TIMEOUT      = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout,
  output logic       busy,
  output logic       rx_inhibit
);

  localparam int MAX_AB  = (INHIBIT_CYCLES > START_SETUP_CYCLES) ? INHIBIT_CYCLES : START_SETUP_CYCLES;
  localparam int MAX_ALL = (MAX_AB > FIRST_EDGE_TIMEOUT) ? MAX_AB : FIRST_EDGE_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);
  localparam int FRM_W   = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(START_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(FRAME_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_START, S_WAIT_FIRST, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [FRM_W-1:0] frm_cnt, frm_cnt_n;
  logic [3:0]       edge_cnt, edge_cnt_n;
  logic [7:0]       data_q, data_q_n;
  logic             parity_q, parity_q_n;
  logic             clk_oe_q, clk_oe_n;
  logic             data_oe_q, data_oe_n;
  logic             ack_q, ack_n;
  logic             err_q, err_n;

  // clk_sync[2] is the previous synced sample, used only for edge detection
  logic [2:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_s, data_s, clk_fall;

  assign clk_s    = clk_sync[1];
  assign data_s   = data_sync[1];
  assign clk_fall = clk_sync[2] & ~clk_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
      state     <= S_IDLE;
      cnt       <= '0;
      frm_cnt   <= '0;
      edge_cnt  <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      state     <= state_n;
      cnt       <= cnt_n;
      frm_cnt   <= frm_cnt_n;
      edge_cnt  <= edge_cnt_n;
      data_q    <= data_q_n;
      parity_q  <= parity_q_n;
      clk_oe_q  <= clk_oe_n;
      data_oe_q <= data_oe_n;
      ack_q     <= ack_n;
      err_q     <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    frm_cnt_n  = frm_cnt;
    edge_cnt_n = edge_cnt;
    data_q_n   = data_q;
    parity_q_n = parity_q;
    clk_oe_n   = clk_oe_q;
    data_oe_n  = data_oe_q;
    ack_n      = ack_q;
    err_n      = err_q;
    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          state_n    = S_INHIBIT;
          cnt_n      = '0;
          frm_cnt_n  = '0;
          edge_cnt_n = '0;
          data_q_n   = tx_data;
          parity_q_n = ~^tx_data;
          ack_n      = 1'b0;
          err_n      = 1'b0;
          clk_oe_n   = 1'b1;
          data_oe_n  = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (cnt >= INH_LAST) begin
          state_n   = S_START;
          cnt_n     = '0;
          data_oe_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_START: begin
        if (cnt >= SETUP_LAST) begin
          state_n  = S_WAIT_FIRST;
          cnt_n    = '0;
          clk_oe_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WAIT_FIRST: begin
        if (clk_fall) begin
          state_n    = S_SHIFT;
          edge_cnt_n = 4'd1;
          frm_cnt_n  = '0;
          data_oe_n  = ~data_q[0];
        end else if (cnt >= FIRST_LAST) begin
          state_n = S_ERR;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_SHIFT: begin
        frm_cnt_n = frm_cnt + 1'b1;
        if (clk_fall) begin
          edge_cnt_n = edge_cnt + 4'd1;
          if (edge_cnt == 4'd9) begin
            state_n   = S_ACK;
            data_oe_n = 1'b0;
          end else if (edge_cnt == 4'd8) begin
            data_oe_n = ~parity_q;
          end else begin
            data_oe_n = ~data_q[edge_cnt[2:0]];
          end
        end else if (frm_cnt >= FRM_LAST) begin
          state_n = S_ERR;
        end
      end
      S_ACK: begin
        frm_cnt_n = frm_cnt + 1'b1;
        if (clk_fall) begin
          state_n    = S_WAIT_IDLE;
          edge_cnt_n = 4'd11;
          ack_n      = ~data_s;
        end else if (frm_cnt >= FRM_LAST) begin
          state_n = S_ERR;
        end
      end
      S_WAIT_IDLE: begin
        frm_cnt_n = frm_cnt + 1'b1;
        if (clk_s && data_s) begin
          state_n = S_DONE;
        end else if (frm_cnt >= FRM_LAST) begin
          state_n = S_ERR;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Every path into ERR releases the pads and records a timeout
    if (state_n == S_ERR) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      err_n     = 1'b1;
      ack_n     = 1'b0;
    end
  end

  assign tx_ready    = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign rx_inhibit  = busy;
  assign done        = (state == S_DONE) || (state == S_ERR);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign ack_ok      = ack_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a behavioural PS/2 device
module tb_ps2_host_tx;

  logic       clk;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       done;
  logic       ack_ok;
  logic       err_timeout;
  logic       busy;
  logic       rx_inhibit;

  logic       dev_clk_low;
  logic       dev_data_low;
  logic [10:0] dev_frame;

  int n_checks;
  int n_pass;
  int cyc;
  int rel_cyc;
  int done_cyc;
  int fall1_cyc;
  int n_done;
  int clk_oe_total;
  logic clk_oe_prev;

  typedef struct {
    logic [10:0] frame;
    logic        ack;
    logic        err;
    logic        chk_frame;
  } sb_t;
  sb_t sb[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .START_SETUP_CYCLES(5),
    .FIRST_EDGE_TIMEOUT(400),
    .FRAME_TIMEOUT(2000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .done(done),
    .ack_ok(ack_ok),
    .err_timeout(err_timeout),
    .busy(busy),
    .rx_inhibit(rx_inhibit)
  );

  // Open-drain wired-AND of host and device on each line
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    sb_t ent;
    if (!reset) begin
      if (clk_oe_prev && !ps2_clk_oe) rel_cyc <= cyc;
      clk_oe_prev <= ps2_clk_oe;
      if (ps2_clk_oe) clk_oe_total <= clk_oe_total + 1;
      if (done) begin
        done_cyc <= cyc;
        n_done   <= n_done + 1;
        check("busy_at_done", {31'd0, busy}, 32'd1);
        check("oe_released_at_done", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          ent = sb.pop_front();
          check("ack_ok", {31'd0, ack_ok}, {31'd0, ent.ack});
          check("err_timeout", {31'd0, err_timeout}, {31'd0, ent.err});
          if (ent.chk_frame) check("device_frame", {21'd0, dev_frame}, {21'd0, ent.frame});
        end
      end
    end
  end

  // Frame as the device samples it: start, d0..d7, parity, stop (bit 0 = start)
  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d, input logic push, input logic [10:0] frame,
                      input logic ack, input logic err, input logic chk_frame);
    sb_t ent;
    ent.frame = frame;
    ent.ack = ack;
    ent.err = err;
    ent.chk_frame = chk_frame;
    if (push) sb.push_back(ent);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_drop", {31'd0, tx_ready}, 32'd0);
  endtask

  // mode 0: normal with ACK, 1: no ACK, 2: never clocks, 3: stop after stop_after edges, 4: reset at edge 4
  task automatic device(input int mode, input int stop_after);
    int k;
    dev_frame = '0;
    k = 0;
    while (!(ps2_clk_in == 1'b1 && ps2_data_in == 1'b0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      check("rts_seen", 32'd0, 32'd1);
      return;
    end
    if (mode == 2) return;
    repeat (30) @(negedge clk);
    dev_frame[0] = ps2_data_in;
    for (int e = 1; e <= 11; e++) begin
      if (mode == 3 && e > stop_after) return;
      if (e == 11 && mode == 0) begin
        dev_data_low = 1'b1;
        repeat (10) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      if (e == 1) fall1_cyc = cyc;
      if (mode == 4 && e == 4) begin
        repeat (4) @(negedge clk);
        check("data_oe_bit3_before_reset", {31'd0, ps2_data_oe}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {28'd0, ps2_clk_oe, ps2_data_oe, busy, tx_ready}, 32'b0001);
        @(negedge clk);
        reset = 1'b0;
        dev_clk_low = 1'b0;
        return;
      end
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      if (e <= 10) dev_frame[e] = ps2_data_in;
      if (e == 11 && mode == 0) begin
        check("tx_ready_in_wait_idle", {31'd0, tx_ready}, 32'd0);
        repeat (10) @(negedge clk);
        dev_data_low = 1'b0;
      end
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || !tx_ready) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) check("wait_done_budget", 32'd0, 32'd1);
  endtask

  logic [7:0] bytes_tbl [4];
  logic       par_tbl   [4];

  initial begin
    int oe_start;
    int done_before;
    bytes_tbl[0] = 8'hED; par_tbl[0] = 1'b1;
    bytes_tbl[1] = 8'hF4; par_tbl[1] = 1'b0;
    bytes_tbl[2] = 8'h01; par_tbl[2] = 1'b0;
    bytes_tbl[3] = 8'hFF; par_tbl[3] = 1'b1;
    n_checks = 0; n_pass = 0; cyc = 0; n_done = 0; clk_oe_total = 0;
    rel_cyc = 0; done_cyc = 0; fall1_cyc = 0; clk_oe_prev = 1'b0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0; dev_frame = '0;
    tx_valid = 1'b0; tx_data = 8'h00;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_outputs",
          {24'd0, ps2_clk_oe, ps2_data_oe, done, ack_ok, err_timeout, busy, rx_inhibit, tx_ready},
          32'b0000_0001);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      oe_start = clk_oe_total;
      send(bytes_tbl[i], 1'b1, make_frame(bytes_tbl[i], par_tbl[i]), 1'b1, 1'b0, 1'b1);
      fork
        device(0, 0);
        begin
          if (i == 2) begin
            repeat (100) @(negedge clk);
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = bytes_tbl[i];
          end
        end
      join
      wait_done(2000);
      if (i == 0) check("clk_oe_high_cycles", clk_oe_total - oe_start, 32'd25);
      check("done_count", n_done, i + 1);
      check("tx_ready_after", {31'd0, tx_ready}, 32'd1);
      repeat (10) @(negedge clk);
    end

    // Device leaves data high at edge 11
    send(8'hF4, 1'b1, make_frame(8'hF4, 1'b0), 1'b0, 1'b0, 1'b1);
    device(1, 0);
    wait_done(2000);
    repeat (10) @(negedge clk);

    // Device never clocks: done 400 cycles after clock release
    send(8'hED, 1'b1, '0, 1'b0, 1'b1, 1'b0);
    device(2, 0);
    wait_done(1000);
    check("first_edge_timeout_latency", done_cyc - rel_cyc, 32'd400);
    repeat (10) @(negedge clk);

    // Device stops after edge 5: 3-cycle sync latency plus 2000 frame cycles
    send(8'hED, 1'b1, '0, 1'b0, 1'b1, 1'b0);
    device(3, 5);
    wait_done(3000);
    check("frame_timeout_latency", done_cyc - fall1_cyc, 32'd2003);
    repeat (10) @(negedge clk);

    done_before = n_done;
    send(8'hF4, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    device(4, 0);
    repeat (50) @(negedge clk);
    check("no_done_after_reset", n_done, done_before);

    send(bytes_tbl[3], 1'b1, make_frame(bytes_tbl[3], par_tbl[3]), 1'b1, 1'b0, 1'b1);
    device(0, 0);
    wait_done(2000);
    check("done_count_final", n_done, done_before + 1);
    check("scoreboard_empty", sb.size(), 32'd0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
